// File: rtl/hex_scroller.sv
// hex_scroller: scrolls a writable message of 7-segment patterns across a
// bank of active-low digits.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   wr_en/addr/data     message buffer write port (pattern active-low, bit0 = a)
//   load, msg_len       latch a new message length and restart the scroll
//   run                 1 = scroll, 0 = freeze divider and display
//   dir                 0 = text moves toward higher digits, 1 = reverse
//   hex                 digit i on bits [7i+6:7i], active-low
//   step, wrap          one-cycle pulses per scroll step / per pointer wrap
//
// Message length is expected to satisfy MAX_LEN >= 2.
module hex_scroller #(
   parameter int NUM_DIGITS = 8,
   parameter int MAX_LEN    = 16,
   parameter int DIV        = 50000000,
   parameter int GAP        = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [$clog2(MAX_LEN)-1:0]    wr_addr,
   input  logic [6:0]                    wr_data,
   input  logic                          load,
   input  logic [$clog2(MAX_LEN):0]      msg_len,
   input  logic                          run,
   input  logic                          dir,
   output logic [7*NUM_DIGITS-1:0]       hex,
   output logic                          step,
   output logic                          wrap
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = AW + 1;
   localparam int IW = $clog2(MAX_LEN + GAP) + 1;
   localparam int FW = $clog2(NUM_DIGITS + 1);
   localparam int CW = $clog2(DIV);

   localparam logic [LW-1:0] MAX_L    = LW'(MAX_LEN);
   localparam logic [IW-1:0] GAP_I    = IW'(GAP);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(NUM_DIGITS);
   localparam logic [6:0]    BLANK    = 7'h7F;

   logic [6:0]    mem [MAX_LEN];
   logic [CW-1:0] div_cnt, div_d;
   logic [IW-1:0] pos, pos_d;
   logic [FW-1:0] fill, fill_d;
   logic [LW-1:0] len_q, len_d;
   logic [IW-1:0] per, per_d;
   logic          tick, step_d, wrap_d, wr_ok;
   logic [NUM_DIGITS-1:0][6:0] hex_d;

   assign tick  = run && (div_cnt == DIV_LAST);
   assign per   = IW'(len_q) + GAP_I;
   assign per_d = IW'(len_d) + GAP_I;
   assign wr_ok = ({1'b0, wr_addr} < MAX_L);

   // Next-state for divider, pointer and fill. load wins over a same-cycle tick.
   always_comb begin
      len_d  = len_q;
      pos_d  = pos;
      fill_d = fill;
      div_d  = div_cnt;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (load) begin
         len_d  = (msg_len > MAX_L) ? MAX_L : msg_len;
         pos_d  = '0;
         fill_d = '0;
         div_d  = '0;
      end else if (tick) begin
         div_d  = '0;
         step_d = 1'b1;
         if (fill != FILL_MAX) fill_d = fill + 1'b1;
         // An empty period keeps pos parked at 0.
         if (per != '0) begin
            if (!dir) begin
               if (pos == per - 1'b1) begin
                  pos_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos + 1'b1;
               end
            end else begin
               if (pos == '0) begin
                  pos_d  = per - 1'b1;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos - 1'b1;
               end
            end
         end
      end else if (run) begin
         div_d = div_cnt + 1'b1;
      end
   end

   // Display is built from next-state values so the registered hex changes in
   // the same cycle as step. The stream index walks down one per digit with a
   // wrap to per-1, which handles periods shorter than the display without a
   // divider. A pending write is forwarded so it shows one cycle later.
   always_comb begin
      logic [IW-1:0] idx;
      idx   = pos_d;
      hex_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i > 0) idx = (idx == '0) ? per_d - 1'b1 : idx - 1'b1;
         if (per_d != '0 && FW'(i) <= fill_d && idx < IW'(len_d)) begin
            if (wr_en && wr_addr == idx[AW-1:0]) hex_d[i] = wr_data;
            else                                 hex_d[i] = mem[idx[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         pos     <= '0;
         fill    <= '0;
         len_q   <= '0;
         step    <= 1'b0;
         wrap    <= 1'b0;
         hex     <= '1;
         for (int k = 0; k < MAX_LEN; k++) mem[k] <= BLANK;
      end else begin
         div_cnt <= div_d;
         pos     <= pos_d;
         fill    <= fill_d;
         len_q   <= len_d;
         step    <= step_d;
         wrap    <= wrap_d;
         hex     <= hex_d;
         if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_hex_scroller.sv
module tb_hex_scroller;

   localparam logic [6:0]  B = 7'h7F, H = 7'h09, E = 7'h06, L = 7'h47, O = 7'h40;
   localparam logic [55:0] ALL1 = {56{1'b1}};

   logic        clk, rst_n, wr_en, load, run, dir;
   logic [3:0]  wr_addr;
   logic [6:0]  wr_data;
   logic [4:0]  msg_len;
   logic [55:0] hex_a, hex_b;
   logic        step_a, wrap_a, step_b, wrap_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic            dir;
      logic [7:0][6:0] hex;
      logic            wrap;
   } vec_t;

   vec_t       tbl [10];
   logic [6:0] hello [5];

   hex_scroller #(.NUM_DIGITS(8), .MAX_LEN(16), .DIV(4), .GAP(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .load(load), .msg_len(msg_len), .run(run), .dir(dir),
      .hex(hex_a), .step(step_a), .wrap(wrap_a));

   hex_scroller #(.NUM_DIGITS(8), .MAX_LEN(16), .DIV(4), .GAP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .load(load), .msg_len(msg_len), .run(run), .dir(dir),
      .hex(hex_b), .step(step_b), .wrap(wrap_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_step(output bit found);
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (step_a) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_row(input int r);
      bit f;
      dir = tbl[r].dir;
      wait_step(f);
      chk($sformatf("row%0d step", r), 56'(f), 56'(1));
      chk($sformatf("row%0d hex", r), hex_a, tbl[r].hex);
      chk($sformatf("row%0d wrap", r), 56'(wrap_a), 56'(tbl[r].wrap));
   endtask

   initial begin
      bit f;
      bit quiet;
      bit early_wrap;

      tbl[0] = '{1'b0, {B,B,B,B,B,B,H,E}, 1'b0};
      tbl[1] = '{1'b0, {B,B,B,B,B,H,E,L}, 1'b0};
      tbl[2] = '{1'b0, {B,B,B,B,H,E,L,L}, 1'b0};
      tbl[3] = '{1'b0, {B,B,B,H,E,L,L,O}, 1'b0};
      tbl[4] = '{1'b0, {B,B,H,E,L,L,O,B}, 1'b0};
      tbl[5] = '{1'b0, {B,H,E,L,L,O,B,B}, 1'b0};
      tbl[6] = '{1'b0, {H,E,L,L,O,B,B,B}, 1'b0};
      tbl[7] = '{1'b0, {E,L,L,O,B,B,B,H}, 1'b1};
      tbl[8] = '{1'b1, {H,E,L,L,O,B,B,B}, 1'b1};
      tbl[9] = '{1'b1, {B,H,E,L,L,O,B,B}, 1'b0};
      hello  = '{H, E, L, L, O};

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      load = 1'b0; msg_len = '0; run = 1'b0; dir = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset hex", hex_a, ALL1);
      chk("reset step", 56'(step_a), 56'(0));
      chk("reset wrap", 56'(wrap_a), 56'(0));
      rst_n = 1'b1;
      @(negedge clk); load = 1'b1; msg_len = 5'd5;
      @(negedge clk); load = 1'b0;
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (hex_a !== ALL1 || step_a) quiet = 1'b0;
      end
      chk("idle blank", 56'(quiet), 56'(1));

      // basic scroll
      for (int k = 0; k < 5; k++) begin
         wr_en = 1'b1; wr_addr = 4'(k); wr_data = hello[k];
         @(negedge clk);
      end
      wr_en = 1'b0; load = 1'b1; msg_len = 5'd5;
      @(negedge clk); load = 1'b0;
      chk("tick0 hex", hex_a, {B,B,B,B,B,B,B,H});
      run = 1'b1;
      for (int r = 0; r < 8; r++) apply_row(r);

      // pause
      run = 1'b0;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (step_a || hex_a !== tbl[7].hex) quiet = 1'b0;
      end
      chk("pause frozen", 56'(quiet), 56'(1));
      run = 1'b1;
      for (int r = 8; r < 10; r++) apply_row(r);

      // load on the tick cycle
      repeat (3) @(negedge clk);
      load = 1'b1; msg_len = 5'd5;
      @(negedge clk); load = 1'b0;
      chk("prio step", 56'(step_a), 56'(0));
      chk("prio wrap", 56'(wrap_a), 56'(0));
      chk("prio hex", hex_a, {B,B,B,B,B,B,B,H});

      // clamp: 20 -> 16, period 19
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 7'h15; dir = 1'b0;
      @(negedge clk); wr_en = 1'b0; load = 1'b1; msg_len = 5'd20;
      @(negedge clk); load = 1'b0;
      early_wrap = 1'b0;
      for (int s = 1; s <= 19; s++) begin
         wait_step(f);
         chk($sformatf("clamp step%0d", s), 56'(f), 56'(1));
         if (s < 19 && wrap_a) early_wrap = 1'b1;
         if (s == 15) chk("clamp d0 at 15", 56'(hex_a[6:0]), 56'(7'h15));
         if (s == 19) begin
            chk("clamp wrap", 56'(wrap_a), 56'(1));
            chk("clamp d0 at wrap", 56'(hex_a[6:0]), 56'(H));
         end
      end
      chk("clamp no early wrap", 56'(early_wrap), 56'(0));

      // live write into a displayed index
      wait_step(f);
      wait_step(f);
      chk("live pre step", 56'(f), 56'(1));
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 7'h00;
      @(negedge clk); wr_en = 1'b0;
      chk("live step", 56'(step_a), 56'(0));
      chk("live hex", hex_a, {B,7'h15,B,B,B,7'h00,E,L});

      // empty message
      load = 1'b1; msg_len = 5'd0;
      @(negedge clk); load = 1'b0;
      chk("len0 hex a", hex_a, ALL1);
      chk("len0 hex b", hex_b, ALL1);
      wait_step(f);
      chk("len0 step a", 56'(f), 56'(1));
      chk("len0 hex a tick", hex_a, ALL1);
      chk("len0 step b", 56'(step_b), 56'(1));
      chk("len0 hex b tick", hex_b, ALL1);
      chk("len0 wrap b", 56'(wrap_b), 56'(0));

      // single character, no gap
      load = 1'b1; msg_len = 5'd1;
      @(negedge clk); load = 1'b0;
      chk("len1 hex b t0", hex_b, {B,B,B,B,B,B,B,7'h00});
      wait_step(f);
      chk("len1 hex b t1", hex_b, {B,B,B,B,B,B,7'h00,7'h00});
      chk("len1 wrap b", 56'(wrap_b), 56'(1));
      repeat (7) wait_step(f);
      chk("len1 step", 56'(f), 56'(1));
      chk("len1 hex b full", hex_b, 56'(0));

      // reset mid-scroll
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst hex a", hex_a, ALL1);
      chk("midrst step", 56'(step_a), 56'(0));
      chk("midrst hex b", hex_b, ALL1);
      @(negedge clk); rst_n = 1'b1; run = 1'b0; load = 1'b1; msg_len = 5'd5;
      @(negedge clk); load = 1'b0;
      chk("midrst buffer cleared", hex_a, ALL1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_scroller.md
Name: hex_scroller

Overview:
- Parametrised scrolling-text engine for a bank of active-low 7-segment digits.
- Holds a writable message buffer of segment patterns and scrolls it across NUM_DIGITS digits at a rate set by an internal tick divider.
- Supports both scroll directions, a run/pause control and a blank gap between repetitions.
- Sits between the board clock and the HEX display pins; glyph-encoding logic upstream writes the buffer.

Parameters:
- NUM_DIGITS, 8, number of display digits driven (digit 0 = rightmost).
- MAX_LEN, 16, message buffer depth in characters.
- DIV, 50000000, clk cycles per scroll step (must be >= 2).
- GAP, 3, blank characters inserted after the message before it repeats (may be 0).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  clog2(MAX_LEN)  buffer index to write.
- wr_data  in  7  segment pattern to store (active-low, bit0 = segment a).
- load  in  1  one-cycle pulse: latch msg_len and restart the scroll.
- msg_len  in  clog2(MAX_LEN)+1  message length in characters, sampled on load.
- run  in  1  1 = scroll, 0 = freeze display and divider.
- dir  in  1  0 = text enters at digit 0 and moves toward digit NUM_DIGITS-1; 1 = pos steps in reverse.
- hex  out  7*NUM_DIGITS  digit i on bits [7i+6:7i], active-low.
- step  out  1  one-cycle pulse on every scroll step.
- wrap  out  1  one-cycle pulse when pos wraps around.

Behaviour:
- Reset (async, rst_n = 0):
  - hex = all ones (blank); step = 0, wrap = 0.
  - div_cnt = 0, pos = 0, fill = 0, len_q = 0.
  - Every buffer entry = 7'h7F.
- Divider:
  - When run = 1, div_cnt counts 0..DIV-1. In the cycle div_cnt = DIV-1 it returns to 0 and an internal tick fires.
  - When run = 0, div_cnt holds and no tick fires.
  - step is registered: it is high in the cycle after the tick.
- Stream model:
  - Period P = len_q + GAP.
  - S[k] = buf[k] for k < len_q; S[k] = 7'h7F for len_q <= k < P.
- Pointer update on tick:
  - dir = 0: pos <= (pos == P-1) ? 0 : pos+1.
  - dir = 1: pos <= (pos == 0) ? P-1 : pos-1.
  - wrap pulses (registered with step) when pos crosses P-1 -> 0 (dir 0) or 0 -> P-1 (dir 1).
  - fill <= min(fill+1, NUM_DIGITS).
- Display mapping:
  - Digit i shows S[(pos - i) mod P] if i <= fill; otherwise it shows 7'h7F (start-up fill, so text enters from an empty display).
  - If P < NUM_DIGITS the pattern repeats across the digits (modulo indexing).
  - hex is registered: it reflects the new pos or fill one clk after the tick, in the same cycle as step.
- Empty and clamped lengths:
  - len_q = 0 and GAP = 0: P = 0; pos is held at 0, all digits are blank, and step still pulses.
  - len_q = 0 and GAP > 0: all digits are blank.
  - On load, msg_len > MAX_LEN is clamped to MAX_LEN.
- load:
  - Next edge: len_q <= clamped msg_len, pos <= 0, fill <= 0, div_cnt <= 0.
  - load has priority over a same-cycle tick; that tick is discarded and step/wrap stay low.
- Buffer writes:
  - wr_en writes buf[wr_addr] <= wr_data at the next edge.
  - wr_addr >= MAX_LEN is ignored.
  - A write to a displayed index appears on hex one cycle later, without waiting for a tick.
  - A same-cycle write and display read of the same index shows the new data one cycle later (registered output).
- Direction change: a dir change mid-scroll takes effect on the next tick; pos is not reset.
- Reset mid-scroll returns everything to the reset state immediately; the buffer is cleared.
- Width and ceiling: pos, P and index arithmetic use clog2(MAX_LEN+GAP)+1 bits; modulo is computed without division (conditional add of P).

Test Plan:
- Reset: hold rst_n = 0 -> hex = all ones, step = 0, wrap = 0. Release, load msg_len = 5 with run = 0 for 20 cycles -> hex stays all ones.
- Basic scroll (DIV = 4, GAP = 3): write "HELLO" codes 09,06,47,47,40; pulse load; run = 1.
  - After tick 0 -> digit 0 = 09, others 7F.
  - After tick 1 -> digit 0 = 06, digit 1 = 09.
  - After tick 8 -> wrap pulses and digit 0 = 09, digit 4 = 40, digits 5..7 = 47,47,06.
- Pause and direction: drop run for 10 cycles -> no step and hex unchanged. Raise run, set dir = 1 -> pos decrements on every step and wrap fires on 0 -> 7 (P = 8).
- Priority and clamp: assert load on the exact tick cycle -> no step that cycle and pos = 0. Load msg_len = 20 with MAX_LEN = 16 -> len_q = 16 and P = 19.
- Live write: while running, write buf[0] = 7'h00 when digit 2 displays index 0 -> digit 2 = 00 one cycle later with no tick.
- Edge lengths: load msg_len = 0 (GAP = 3) -> all blank, step continues. Load msg_len = 1 with GAP = 0 -> after fill completes, every digit shows buf[0].
